// File: rtl/wb_master_engine.sv
// Wishbone classic-cycle initiator: buffers commands in a small FIFO, runs them
// one at a time as single bus cycles and returns one response per cycle.
// A watchdog aborts any cycle the slave never terminates.
module wb_master_engine #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int CMD_DEPTH     = 4,
  parameter int TIMEOUT       = 256
) (
  input  logic                       clk,
  input  logic                       rstn,
  // command port
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [WB_ADDR_WIDTH-1:0]   cmd_adr,
  input  logic [WB_DATA_WIDTH-1:0]   cmd_dat,
  input  logic [WB_DATA_WIDTH/8-1:0] cmd_sel,
  // response port
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WB_DATA_WIDTH-1:0]   rsp_dat,
  output logic                       rsp_err,
  output logic                       rsp_timeout,
  // Wishbone master
  output logic                       CYC,
  output logic                       STB,
  output logic                       WE,
  output logic [WB_ADDR_WIDTH-1:0]   ADR,
  output logic [WB_DATA_WIDTH-1:0]   DAT_W,
  output logic [WB_DATA_WIDTH/8-1:0] SEL,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_R,
  input  logic                       ACK,
  input  logic                       ERR
);

  localparam int SEL_W = WB_DATA_WIDTH / 8;
  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic                     we;
    logic [WB_ADDR_WIDTH-1:0] adr;
    logic [WB_DATA_WIDTH-1:0] dat;
    logic [SEL_W-1:0]         sel;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RSP
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  cmd_t             head;

  state_t           state_q;
  state_t           state_d;

  assign full      = (count == (PTR_W + 1)'(CMD_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = rstn && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && !empty;
  assign head      = mem[rd_ptr];

  // Storage array: written on push only.
  // NOTE: the data array carries no reset; the pointers and count already
  // make every stale entry unreachable, and a resettable array costs flops.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
    end
  end

  // Pointers and occupancy; both pointers wrap naturally at a power-of-2 depth.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bus-cycle FSM
  // ---------------------------------------------------------------------------
  logic [WD_W-1:0]          wd_q, wd_d;
  logic                     cyc_d, stb_d, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_w_d;
  logic [SEL_W-1:0]         sel_d;
  logic                     rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [WB_DATA_WIDTH-1:0] rsp_dat_d;

  // State and registered outputs; reset aborts any cycle and drops any response.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      CYC         <= 1'b0;
      STB         <= 1'b0;
      WE          <= 1'b0;
      ADR         <= '0;
      DAT_W       <= '0;
      SEL         <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_dat     <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      CYC         <= cyc_d;
      STB         <= stb_d;
      WE          <= we_d;
      ADR         <= adr_d;
      DAT_W       <= dat_w_d;
      SEL         <= sel_d;
      rsp_valid   <= rsp_valid_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      rsp_dat     <= rsp_dat_d;
    end
  end

  // Next state and next register values: ERR beats ACK, and either beats the
  // watchdog expiring on the same edge.
  // NOTE: every signal gets a hold default before the case so no path through
  // the block leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    cyc_d         = CYC;
    stb_d         = STB;
    we_d          = WE;
    adr_d         = ADR;
    dat_w_d       = DAT_W;
    sel_d         = SEL;
    rsp_valid_d   = rsp_valid;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    rsp_dat_d     = rsp_dat;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_BUS;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = head.we;
          adr_d   = head.adr;
          dat_w_d = head.dat;
          sel_d   = head.sel;
          wd_d    = '0;
        end
      end

      S_BUS: begin
        if (ERR) begin
          state_d       = S_RSP;
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_dat_d     = '0;
        end else if (ACK) begin
          state_d       = S_RSP;
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_dat_d     = WE ? '0 : DAT_R;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d       = S_RSP;
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b1;
          rsp_dat_d     = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
